dcache_line_memory: RTL and testbench
=====================================

Name: dcache_line_memory

Overview:
- Main-memory responder on the memory side of the data-cache controller.
- Serves 256-bit (32-byte) line reads and writes with a fixed, parameterised latency.
- Signals completion with a one-cycle ack pulse.
- Models off-chip memory seen by the cache miss/write-back path. One outstanding request at a time.

Parameters:
- LATENCY, 10: edges from request capture to ack assertion, inclusive of the capture edge; legal range 2..255.
- DEPTH, 512: number of 256-bit lines; power of two.
- IDX_W, 9: log2(DEPTH); line index width.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- enable_i  input  1  request strobe from cache controller.
- write_i  input  1  1 = line write, 0 = line read; sampled with enable_i.
- addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[IDX_W+4:5]; upper bits ignored, so aliasing is by design.
- data_i  input  256  write line data; sampled with enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  256  read line data; valid while ack_o=1 for reads.
- busy_o  output  1  high from the capture edge until ack_o deasserts.

Behaviour:
- Reset, synchronous on rst_i=1 at a rising edge:
  - state=IDLE, counter=0, ack_o=0, busy_o=0, data_o=0.
  - Line array contents are NOT cleared; the bench preloads by hierarchical access.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - If enable_i=1 at an edge, latch index, write_i and data_i; set counter=1, busy_o=1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - While counter != LATENCY-1, counter increments each edge.
  - At the edge where counter == LATENCY-1, perform the access and go to ACK with ack_o=1:
    - Write: mem[idx] <= latched data; data_o unchanged.
    - Read: data_o <= mem[idx].
  - Net timing: request captured at edge E0; ack_o high for exactly the cycle between edges E0+LATENCY-1 and E0+LATENCY.
- ACK:
  - Next edge returns to IDLE with ack_o=0, busy_o=0, counter=0.
  - No request is accepted on this edge, even if enable_i=1.
- Request spacing:
  - enable_i is sampled only in IDLE.
  - Changes to addr_i, data_i, write_i or enable_i during WAIT/ACK have no effect; latched values are used.
  - Minimum capture-to-capture spacing is LATENCY+1 edges.
  - If enable_i is still high in IDLE after an ack, it is a new request. The controller must drop enable_i on seeing ack_o to avoid a repeat.
- data_o holds the last read result until the next read ack, and through write acks.
- Read-after-write to the same index returns the written line.
- Reset mid-operation (WAIT or ACK): request aborted, no memory write, next state IDLE, outputs at reset values.
- Reset has priority over all other events on the same edge.

Test Plan:
- Read: preload mem[3]=256'hA5..A5; enable_i=1, write_i=0, addr_i=32'h0000_0060 at edge E0 -> ack_o=1 only in cycle E0+9..E0+10 with data_o=256'hA5..A5; busy_o=1 from E0 through that cycle.
- Write then read: write 256'h1234_..._CDEF to addr 32'h0000_0440 (index 34), drop enable on ack, then read the same addr -> second ack returns 256'h1234_..._CDEF; data_o unchanged (previous value) during the write ack.
- Held enable: enable_i=1 continuously with a read of index 5 -> first ack at E0+9, IDLE at E0+10, second capture at E0+11, second ack at E0+20; exactly two ack pulses over 22 cycles.
- Ignore while busy: capture a read of index 7, then at E0+3 drive addr index 9, write_i=1, new data -> ack at E0+9 returns mem[7]; mem[9] unchanged.
- Reset mid-op: capture a write to index 2 (old value X0), assert rst_i at E0+5 -> ack_o never pulses, busy_o=0, data_o=0 after reset edge; a following read of index 2 returns X0.
- Aliasing: write to addr 32'h0000_4020 (index 1, upper bit 14 set) -> a read of addr 32'h0000_0020 returns the written line; low 5 address bits 5'h1F change nothing.

Source files
------------

// File: rtl/dcache_line_memory.sv
// Main-memory responder for the data-cache miss/write-back path: one 256-bit line
// access at a time, completing LATENCY edges after capture with a one-cycle ack.
module dcache_line_memory #(
  parameter int LATENCY = 10,
  parameter int DEPTH   = 512,
  parameter int IDX_W   = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         enable_i,
  input  logic         write_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wr_q, wr_d;
  logic [255:0]     wdata_q, wdata_d;
  logic [255:0]     rdata_q, rdata_d;
  logic             access;

  logic [255:0]     mem_q [DEPTH];

  // Upper address bits alias by design and the low 5 bits select bytes within a line.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          idx_d   = addr_i[IDX_W+4:5];
          wr_d    = write_i;
          wdata_d = data_i;
          cnt_d   = 8'd1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          access  = 1'b1;
          state_d = ACK;
          if (!wr_q) rdata_d = mem_q[idx_q];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK: begin
        // Enable is deliberately not sampled here; the next capture waits for IDLE.
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request latches only matter while busy, so they carry no reset.
  always_ff @(posedge clk_i) begin
    idx_q   <= idx_d;
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && access && wr_q) mem_q[idx_q] <= wdata_q;
  end

  assign ack_o  = (state_q == ACK);
  assign busy_o = (state_q != IDLE);
  assign data_o = rdata_q;

endmodule

// File: tb/tb_dcache_line_memory.sv
// Randomized bench for dcache_line_memory: a plain line-array model predicts ack timing,
// busy, read data and data_o hold behaviour, alongside the directed scenarios.
module tb_dcache_line_memory;
  localparam int LAT   = 10;
  localparam int DEPTH = 512;

  logic         clk_i = 1'b0;
  logic         rst_i, enable_i, write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         ack_o, busy_o;
  logic [255:0] data_o;

  int checks = 0;
  int fails  = 0;

  logic [255:0] mem_m [DEPTH];
  logic [255:0] dout_m;

  dcache_line_memory #(.LATENCY(LAT), .DEPTH(DEPTH), .IDX_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .write_i(write_i),
    .addr_i(addr_i), .data_i(data_i), .ack_o(ack_o), .data_o(data_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic garbage();
    enable_i = 1'($urandom);
    write_i  = 1'b1;
    addr_i   = $urandom;
    data_i   = rnd256();
  endtask

  // Issue one request; returns after the edge that drops ack (ready for next capture).
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [255:0] d);
    int idx;
    idx = int'(addr[13:5]);
    enable_i = 1'b1; write_i = wr; addr_i = addr; data_i = d;
    for (int k = 0; k < LAT; k++) begin
      tick();
      chk($sformatf("ack k=%0d", k), 256'(ack_o), 256'(k == LAT - 1));
      chk($sformatf("busy k=%0d", k), 256'(busy_o), 256'd1);
      if (k == LAT - 1) begin
        if (wr) mem_m[idx] = d;
        else    dout_m = mem_m[idx];
        chk(wr ? "data_o hold on wr ack" : "rd data", data_o, dout_m);
        enable_i = 1'b0;
      end else begin
        garbage();
      end
    end
    tick();
    chk("ack drop", 256'(ack_o), 256'd0);
    chk("busy drop", 256'(busy_o), 256'd0);
  endtask

  task automatic held_enable(input int idx);
    int acks;
    acks = 0;
    enable_i = 1'b1; write_i = 1'b0; addr_i = 32'(idx) << 5; data_i = '0;
    for (int k = 0; k < 22; k++) begin
      tick();
      chk($sformatf("held ack k=%0d", k), 256'(ack_o), 256'((k == 9) || (k == 20)));
      if (ack_o) begin
        acks++;
        chk("held data", data_o, mem_m[idx]);
      end
      if (k == 21) enable_i = 1'b0;
    end
    dout_m = mem_m[idx];
    chk("held ack count", 256'(acks), 256'd2);
    tick();
  endtask

  task automatic reset_midop(input int idx);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'(idx) << 5; data_i = rnd256();
    for (int k = 0; k < 5; k++) begin
      tick();
      enable_i = 1'b0;
      if (k == 4) rst_i = 1'b1;
    end
    tick();
    chk("rst ack", 256'(ack_o), 256'd0);
    chk("rst busy", 256'(busy_o), 256'd0);
    chk("rst data", data_o, 256'd0);
    dout_m = '0;
    rst_i = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      tick();
      chk("rst no ack", 256'(ack_o), 256'd0);
    end
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b0; write_i = 1'b0; addr_i = '0; data_i = '0;
    tick(); tick();
    chk("reset ack", 256'(ack_o), 256'd0);
    chk("reset busy", 256'(busy_o), 256'd0);
    chk("reset data", data_o, 256'd0);
    rst_i = 1'b0;
    dout_m = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = rnd256();
      dut.mem_q[i] = mem_m[i];
    end
    mem_m[3] = {32{8'hA5}};
    dut.mem_q[3] = mem_m[3];
    tick();

    do_req(1'b0, 32'h0000_0060, '0);
    do_req(1'b1, 32'h0000_0440, {8{32'h1234_CDEF}});
    do_req(1'b0, 32'h0000_0440, '0);
    held_enable(5);
    do_req(1'b0, 32'h0000_00E0, '0);
    do_req(1'b0, 32'h0000_0120, '0);
    reset_midop(2);
    do_req(1'b0, 32'h0000_0040, '0);
    do_req(1'b1, 32'h0000_403F, {16{16'hBEEF}});
    do_req(1'b0, 32'h0000_0020, '0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = $urandom;
      a[13:5] = 9'($urandom_range(0, 15));
      do_req(1'($urandom), a, rnd256());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
